// File: rtl/uart_msg_sequencer_if.sv
// Control and UART-side signals of the message sequencer.
// master = requester plus UART TX core, slave = sequencer.
interface uart_msg_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              Start;
    logic              Periodic;
    logic              Abort;
    logic [ADDR_W-1:0] MsgBase;
    logic [ADDR_W-1:0] MsgLen;
    logic              TxEmpty;
    logic              XMitGo;
    logic [DATA_W-1:0] TxData;
    logic              Busy;
    logic              Done;
    logic              Aborted;
    logic [ADDR_W-1:0] BytesSent;

    modport master (
        output Start, Periodic, Abort, MsgBase, MsgLen, TxEmpty,
        input  XMitGo, TxData, Busy, Done, Aborted, BytesSent
    );

    modport slave (
        input  Start, Periodic, Abort, MsgBase, MsgLen, TxEmpty,
        output XMitGo, TxData, Busy, Done, Aborted, BytesSent
    );
endinterface

// File: rtl/uart_msg_sequencer.sv
// Streams a ROM-resident message into a UART transmitter.
// Triggered by Start and/or a periodic tick; supports abort.
module uart_msg_sequencer #(
    parameter int    DATA_W    = 8,
    parameter int    ADDR_W    = 8,
    parameter int    PERIOD    = 50_000_000,
    parameter string INIT_FILE = "ROM.mif"
) (
    input logic Clock,
    input logic Reset,
    uart_msg_sequencer_if.slave bus
);
    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] TLAST = CW'(PERIOD - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, SENT, WAIT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] len, len_nxt;
    logic [ADDR_W-1:0] sent, sent_nxt, sent_inc;
    logic              go, go_nxt;
    logic              busy, busy_nxt;
    logic              done, done_nxt;
    logic              abrt, abrt_nxt;
    logic              pend, pend_nxt;
    logic [CW-1:0]     cnt;
    logic              tick;

    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] rom [2**ADDR_W];

    assign tick = (cnt == TLAST);

    always_ff @(posedge Clock) begin
        if (Reset) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            addr  <= '0;
            len   <= '0;
            sent  <= '0;
            go    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abrt  <= 1'b0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            len   <= len_nxt;
            sent  <= sent_nxt;
            go    <= go_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            abrt  <= abrt_nxt;
            pend  <= pend_nxt;
        end
    end

    assign sent_inc = sent + 1'b1;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        len_nxt   = len;
        sent_nxt  = sent;
        go_nxt    = go;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        abrt_nxt  = 1'b0;
        pend_nxt  = pend;
        unique case (state)
            IDLE: begin
                if (bus.Start | (bus.Periodic & tick)) begin
                    addr_nxt  = bus.MsgBase;
                    len_nxt   = bus.MsgLen;
                    sent_nxt  = '0;
                    busy_nxt  = 1'b1;
                    pend_nxt  = 1'b0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (len == '0) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (bus.Abort) begin
                    abrt_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (bus.TxEmpty) begin
                    go_nxt    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // an abort here lets the byte in flight finish first
                if (bus.Abort) pend_nxt = 1'b1;
                if (!bus.TxEmpty) begin
                    go_nxt    = 1'b0;
                    state_nxt = SENT;
                end
            end
            SENT: begin
                sent_nxt = sent_inc;
                if (sent_inc == len) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (pend | bus.Abort) begin
                    abrt_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.Abort) begin
                    abrt_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (bus.TxEmpty) begin
                    go_nxt    = 1'b1;
                    state_nxt = SEND;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.XMitGo    = go;
    assign bus.TxData    = rom[addr];
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.Aborted   = abrt;
    assign bus.BytesSent = sent;
endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Directed bench for uart_msg_sequencer with a small UART TX model.
module tb_uart_msg_sequencer;
    localparam int DW = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_msg_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    uart_msg_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .PERIOD(50), .INIT_FILE("ROM.mif")
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0, abrt_cnt = 0, both_cnt = 0, olap_cnt = 0;
    int d0, a0, n1, n2;

    logic       mempty = 1'b1;
    logic       hold = 1'b0;
    int         ubusy = 0;
    logic [7:0] log_q[$];
    logic [7:0] hello[6] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
    logic [7:0] wrap[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    assign bus.TxEmpty = mempty & ~hold;

    // UART model: accepts a byte when idle, stays busy two cycles
    always @(negedge clk) begin
        if (ubusy != 0) begin
            ubusy = ubusy - 1;
            if (ubusy == 0) mempty = 1'b1;
        end else if (bus.XMitGo && mempty) begin
            mempty = 1'b0;
            ubusy = 2;
            log_q.push_back(bus.TxData);
        end
    end

    always @(negedge clk) begin
        if (bus.Done) done_cnt++;
        if (bus.Aborted) abrt_cnt++;
        if (bus.Done && bus.Aborted) both_cnt++;
        if ((bus.Done || bus.Aborted) && bus.Busy) olap_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] logat(input int i);
        return (i < log_q.size()) ? {24'h0, log_q[i]} : 32'hDEAD;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.Busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 300), 1);
    endtask

    task automatic wait_go(input int k, input string tag);
        int n = 0;
        int seen = 0;
        logic p = bus.XMitGo;
        while (seen < k && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.XMitGo && !p) seen++;
            p = bus.XMitGo;
        end
        chk(tag, seen, k);
    endtask

    task automatic wait_rise(output int n);
        logic p = bus.Busy;
        n = 0;
        while (n < 120) begin
            @(negedge clk);
            n++;
            if (bus.Busy && !p) break;
            p = bus.Busy;
        end
    endtask

    task automatic trig(input logic [7:0] base, input logic [7:0] len);
        bus.MsgBase = base;
        bus.MsgLen = len;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Periodic = 1'b0;
        bus.Abort = 1'b0;
        bus.MsgBase = '0;
        bus.MsgLen = '0;
        for (int i = 0; i < 256; i++) dut.rom[i] = 8'h00;
        for (int i = 0; i < 6; i++) dut.rom[8'h10 + i] = hello[i];
        dut.rom[8'hFE] = 8'hA1;
        dut.rom[8'hFF] = 8'hB2;
        dut.rom[8'h00] = 8'hC3;
        dut.rom[8'h01] = 8'hD4;
        repeat (2) @(negedge clk);
        chk("rst_go", bus.XMitGo, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_abrt", bus.Aborted, 0);
        chk("rst_cnt", bus.BytesSent, 0);
        chk("rst_data", bus.TxData, 8'hC3);
        rst = 1'b0;
        @(negedge clk);

        // HELLO message; inputs changed mid-message must not matter
        log_q.delete();
        d0 = done_cnt;
        bus.MsgBase = 8'h10;
        bus.MsgLen = 8'd6;
        bus.Start = 1'b1;
        @(negedge clk);
        chk("t1_busy", bus.Busy, 1);
        chk("t1_go0", bus.XMitGo, 0);
        bus.Start = 1'b0;
        bus.MsgBase = 8'h55;
        bus.MsgLen = 8'd2;
        @(negedge clk);
        chk("t1_go1", bus.XMitGo, 1);
        wait_idle("t1_to");
        chk("t1_done", bus.Done, 1);
        @(negedge clk);
        chk("t1_n", log_q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t1_b%0d", i), logat(i), hello[i]);
        chk("t1_cnt", bus.BytesSent, 6);
        chk("t1_ndone", done_cnt - d0, 1);

        // empty message
        log_q.delete();
        bus.MsgLen = 8'd0;
        bus.Start = 1'b1;
        @(negedge clk);
        chk("t2_busy", bus.Busy, 1);
        chk("t2_done0", bus.Done, 0);
        bus.Start = 1'b0;
        @(negedge clk);
        chk("t2_busy0", bus.Busy, 0);
        chk("t2_done", bus.Done, 1);
        chk("t2_go", bus.XMitGo, 0);
        @(negedge clk);
        chk("t2_pulse", bus.Done, 0);
        chk("t2_n", log_q.size(), 0);
        bus.Abort = 1'b1;
        @(negedge clk);
        bus.Abort = 1'b0;
        chk("idle_abrt", bus.Aborted, 0);
        chk("idle_busy", bus.Busy, 0);

        // address wrap
        log_q.delete();
        trig(8'hFE, 8'd4);
        wait_idle("t3_to");
        @(negedge clk);
        chk("t3_n", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_b%0d", i), logat(i), wrap[i]);
        chk("t3_cnt", bus.BytesSent, 4);

        // abort while second byte is in SEND
        log_q.delete();
        d0 = done_cnt;
        a0 = abrt_cnt;
        trig(8'h10, 8'd5);
        wait_go(2, "t5_go2");
        bus.Abort = 1'b1;
        @(negedge clk);
        bus.Abort = 1'b0;
        wait_idle("t5_to");
        chk("t5_abrt", bus.Aborted, 1);
        chk("t5_done", bus.Done, 0);
        chk("t5_cnt", bus.BytesSent, 2);
        chk("t5_go", bus.XMitGo, 0);
        @(negedge clk);
        chk("t5_pulse", bus.Aborted, 0);
        chk("t5_ndone", done_cnt - d0, 0);
        chk("t5_nabrt", abrt_cnt - a0, 1);
        chk("t5_n", log_q.size(), 2);

        // abort while waiting for the UART
        trig(8'h10, 8'd5);
        wait_go(1, "t5w_go1");
        hold = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5w_busy", bus.Busy, 1);
        chk("t5w_go0", bus.XMitGo, 0);
        chk("t5w_cnt", bus.BytesSent, 1);
        bus.Abort = 1'b1;
        @(negedge clk);
        bus.Abort = 1'b0;
        chk("t5w_idle", bus.Busy, 0);
        chk("t5w_abrt", bus.Aborted, 1);
        chk("t5w_go", bus.XMitGo, 0);
        hold = 1'b0;
        repeat (4) @(negedge clk);

        // reset mid-message, then LOAD stall
        d0 = done_cnt;
        a0 = abrt_cnt;
        trig(8'h10, 8'd6);
        wait_go(2, "t6_go2");
        rst = 1'b1;
        @(negedge clk);
        chk("t6_go", bus.XMitGo, 0);
        chk("t6_busy", bus.Busy, 0);
        chk("t6_done", bus.Done, 0);
        chk("t6_abrt", bus.Aborted, 0);
        chk("t6_cnt", bus.BytesSent, 0);
        chk("t6_data", bus.TxData, 8'hC3);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_nopulse", (done_cnt - d0) + (abrt_cnt - a0), 0);
        log_q.delete();
        hold = 1'b1;
        trig(8'h10, 8'd2);
        repeat (4) @(negedge clk);
        chk("t6_load_busy", bus.Busy, 1);
        chk("t6_load_go", bus.XMitGo, 0);
        hold = 1'b0;
        @(negedge clk);
        chk("t6_go1", bus.XMitGo, 1);
        wait_idle("t6_to");
        chk("t6_cnt2", bus.BytesSent, 2);
        @(negedge clk);
        chk("t6_n", log_q.size(), 2);

        // periodic repeat, then Start coincident with a tick
        bus.MsgBase = 8'h10;
        bus.MsgLen = 8'd3;
        bus.Periodic = 1'b1;
        wait_rise(n1);
        chk("t4_first", 32'(n1 < 60), 1);
        wait_rise(n2);
        chk("t4_period", n2, 50);
        repeat (30) @(negedge clk);
        log_q.delete();
        d0 = done_cnt;
        repeat (19) @(negedge clk);
        chk("t4_idle", bus.Busy, 0);
        bus.Start = 1'b1;
        @(negedge clk);
        chk("t4_busy", bus.Busy, 1);
        bus.Start = 1'b0;
        bus.Periodic = 1'b0;
        wait_idle("t4_to");
        @(negedge clk);
        chk("t4_n", log_q.size(), 3);
        chk("t4_ndone", done_cnt - d0, 1);
        repeat (60) @(negedge clk);
        chk("t4_single", done_cnt - d0, 1);

        chk("both_hi", both_cnt, 0);
        chk("pulse_busy", olap_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
